keypad_scan: RTL and testbench



---
 rtl/keypad_pkg.sv | 47 ++++
 rtl/keypad_debounce.sv | 58 +++++
 rtl/keypad_scan.sv | 113 +++++++++++
 tb/tb_keypad_scan.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and helpers for the keypad front end.
//   KEY_W        width of the one-hot key vector (bit index = row*COLS + col)
//   ROWS, COLS   matrix geometry
//   KEY_*        key positions as seen by the downstream one-hot-to-BCD decoder
//   popcount16   number of set bits in a key vector
//   onehot_to_idx binary index of the (highest) set bit of a key vector
package keypad_pkg;

  localparam int KEY_W = 16;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;

  localparam int KEY_ENTER   = 0;
  localparam int KEY_0       = 3;
  localparam int KEY_3       = 5;
  localparam int KEY_2       = 6;
  localparam int KEY_1       = 7;
  localparam int KEY_CLR_ALL = 8;
  localparam int KEY_6       = 9;
  localparam int KEY_5       = 10;
  localparam int KEY_4       = 11;
  localparam int KEY_CLR     = 12;
  localparam int KEY_9       = 13;
  localparam int KEY_8       = 14;
  localparam int KEY_7       = 15;

  function automatic logic [4:0] popcount16(input logic [KEY_W-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int k = 0; k < KEY_W; k++) begin
      c = c + {4'd0, v[k]};
    end
    return c;
  endfunction

  function automatic logic [3:0] onehot_to_idx(input logic [KEY_W-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 0; k < KEY_W; k++) begin
      if (v[k]) begin
        idx = 4'(k);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: snapshot-stability filter for the 16-bit key matrix.
//   clk, rst      clock and synchronous active-high reset
//   snapshot_i    completed full-scan snapshot (valid when scan_done_i)
//   scan_done_i   one-cycle pulse at the end of each full scan
//   debounced_o   snapshot that has been seen DEBOUNCE_SCANS scans in a row
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] snapshot_i,
  input  logic             scan_done_i,
  output logic [KEY_W-1:0] debounced_o
);

  // Counter must be able to hold DEBOUNCE_SCANS itself.
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [KEY_W-1:0] prev_q, prev_d;
  logic [KEY_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stability counting: a new pattern counts as its first scan.
  always_comb begin
    prev_d = prev_q;
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    if (scan_done_i) begin
      if (snapshot_i == prev_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end else begin
        cnt_d  = CNT_W'(1);
        prev_d = snapshot_i;
      end
      if (cnt_d == CNT_MAX) begin
        deb_d = snapshot_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      deb_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign debounced_o = deb_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with debounce.
//   clk, rst   clock and synchronous active-high reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    column drive, active-low, one bit low at a time
//   onehot     debounced single-key vector, zero when idle or chorded
//   key_valid  one-cycle strobe on each new single-key press
//   key_code   binary index of the last valid key (holds after release)
//   multi_key  high while more than one key is debounced down
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_out,
  output logic [KEY_W-1:0] onehot,
  output logic             key_valid,
  output logic [3:0]       key_code,
  output logic             multi_key
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

  logic [ROWS-1:0]   sync1_q, sync2_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_idx_q;
  logic [COLS-1:0]   col_q;
  logic [KEY_W-1:0]  snap_q, snap_d;
  logic [KEY_W-1:0]  onehot_q;
  logic              kv_q;
  logic [3:0]        code_q;
  logic              multi_q;

  logic              slot_last_s;
  logic              scan_done_s;
  logic [KEY_W-1:0]  debounced_s;
  logic [4:0]        pop_s;
  logic              single_s;

  assign slot_last_s = (slot_q == SLOT_LAST);
  assign scan_done_s = slot_last_s && (col_idx_q == 2'd3);

  // Sample the current column at slot end, after SCAN_DIV-1 settle cycles.
  always_comb begin
    snap_d = snap_q;
    if (slot_last_s) begin
      for (int r = 0; r < ROWS; r++) begin
        snap_d[{r[1:0], col_idx_q}] = ~sync2_q[r];
      end
    end
  end

  // The filter sees the snapshot including the column-3 bits written this cycle.
  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .snapshot_i (snap_d),
    .scan_done_i(scan_done_s),
    .debounced_o(debounced_s)
  );

  assign pop_s    = popcount16(debounced_s);
  assign single_s = (pop_s == 5'd1);

  // Synchronizer, scan sequencer, snapshot and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      slot_q    <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 4'b1110;
      snap_q    <= '0;
      onehot_q  <= '0;
      kv_q      <= 1'b0;
      code_q    <= 4'd0;
      multi_q   <= 1'b0;
    end else begin
      sync1_q <= row_in;
      sync2_q <= sync1_q;
      snap_q  <= snap_d;
      if (slot_last_s) begin
        slot_q    <= '0;
        col_idx_q <= col_idx_q + 2'd1;
        col_q     <= {col_q[2:0], col_q[3]};
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
      onehot_q <= single_s ? debounced_s : '0;
      multi_q  <= (pop_s > 5'd1);
      // Strobe on any change to a different single key; release is silent.
      if (single_s && (debounced_s != onehot_q)) begin
        kv_q   <= 1'b1;
        code_q <= onehot_to_idx(debounced_s);
      end else begin
        kv_q <= 1'b0;
      end
    end
  end

  assign col_out   = col_q;
  assign onehot    = onehot_q;
  assign key_valid = kv_q;
  assign key_code  = code_q;
  assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        multi_key;

  logic [15:0] keys = 16'h0000;   // physically pressed keys

  int total = 0;
  int bad   = 0;
  int kv_cnt = 0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .onehot   (onehot),
    .key_valid(key_valid),
    .key_code (key_code),
    .multi_key(multi_key)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row reads low if a pressed key connects it to a low column.
  function automatic logic [3:0] matrix(input logic [15:0] k, input logic [3:0] c);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i] = ~|(k[i*4 +: 4] & ~c);
    end
    return r;
  endfunction

  assign row_in = matrix(keys, col_out);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic [3:0] rin_s;
  logic       rst_s;
  initial forever begin
    @(posedge clk);
    rin_s = row_in;
    rst_s = rst;
    if (key_valid) kv_cnt++;
  end

  // Reference model (scan time arithmetic) plus per-cycle comparison.
  initial begin : model
    int          t;
    bit          ok;
    logic [3:0]  h1, h2;
    logic [15:0] snap, prev, deb, m_oh, nxt;
    int          cnt, pop, col;
    logic        m_kv, m_multi;
    logic [3:0]  m_code, m_col;
    ok = 1'b0;
    t = 0; h1 = 4'hF; h2 = 4'hF; snap = 0; prev = 0; deb = 0; cnt = 0;
    m_oh = 0; m_kv = 0; m_code = 0; m_multi = 0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        ok = 1'b1;
        t = 0; h1 = 4'hF; h2 = 4'hF; snap = 0; prev = 0; deb = 0; cnt = 0;
        m_oh = 0; m_kv = 0; m_code = 0; m_multi = 0;
      end else if (ok) begin
        pop     = $countones(deb);
        m_multi = (pop > 1);
        nxt     = (pop == 1) ? deb : 16'h0000;
        m_kv    = (nxt != 16'h0000) && (nxt != m_oh);
        if (m_kv) begin
          for (int k = 0; k < 16; k++) if (nxt[k]) m_code = 4'(k);
        end
        m_oh = nxt;
        if (t % SD == SD - 1) begin
          col = (t / SD) % 4;
          for (int r = 0; r < 4; r++) snap[r*4 + col] = ~h2[r];
          if (col == 3) begin
            if (snap == prev) cnt = (cnt < DS) ? cnt + 1 : DS;
            else begin cnt = 1; prev = snap; end
            if (cnt == DS) deb = snap;
          end
        end
        h2 = h1;
        h1 = rin_s;
        t++;
      end
      if (ok) begin
        m_col = ~(4'b0001 << ((t / SD) % 4));
        chk("m_col_out",   {28'd0, col_out},   {28'd0, m_col});
        chk("m_onehot",    {16'd0, onehot},    {16'd0, m_oh});
        chk("m_key_valid", {31'd0, key_valid}, {31'd0, m_kv});
        chk("m_key_code",  {28'd0, key_code},  {28'd0, m_code});
        chk("m_multi_key", {31'd0, multi_key}, {31'd0, m_multi});
      end
    end
  end

  task automatic wait_kv(input string nm, output int lat);
    bit found;
    found = 1'b0;
    lat = 0;
    while (!found && lat < 120) begin
      @(negedge clk);
      lat++;
      if (key_valid) found = 1'b1;
    end
    chk({nm, "_strobe_seen"}, {31'd0, found}, 32'd1);
  endtask

  initial begin : stim
    logic [3:0] col_tbl [4];
    int lat, kv0;
    col_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_col_out", {28'd0, col_out}, 32'h0000_000E);
    chk("rst_onehot",  {16'd0, onehot},  32'd0);
    chk("rst_kv",      {31'd0, key_valid}, 32'd0);
    chk("rst_code",    {28'd0, key_code},  32'd0);
    chk("rst_multi",   {31'd0, multi_key}, 32'd0);
    rst = 1'b0;

    // Idle scan sequence
    for (int i = 0; i < 16; i++) begin
      chk("col_seq", {28'd0, col_out}, {28'd0, col_tbl[i/4]});
      @(negedge clk);
    end
    repeat (16) @(negedge clk);
    chk("idle_no_strobe", kv_cnt, 32'd0);

    // Key 6 (row1/col2): latency window, value, release
    kv0 = kv_cnt;
    keys = 16'h0040;
    wait_kv("k6", lat);
    chk("k6_latency_ok", {31'd0, (lat >= 35 && lat <= 68)}, 32'd1);
    chk("k6_onehot", {16'd0, onehot}, 32'h0000_0040);
    chk("k6_code",   {28'd0, key_code}, 32'd6);
    repeat (40) @(negedge clk);
    chk("k6_one_pulse", kv_cnt - kv0, 32'd1);
    keys = 16'h0000;
    repeat (80) @(negedge clk);
    chk("k6_rel_onehot", {16'd0, onehot}, 32'd0);
    chk("k6_rel_code",   {28'd0, key_code}, 32'd6);
    chk("k6_rel_nostrobe", kv_cnt - kv0, 32'd1);

    // Bouncing key 0, then steady
    kv0 = kv_cnt;
    for (int i = 0; i < 16; i++) begin
      keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      repeat (5) @(negedge clk);
    end
    chk("bounce_no_strobe", kv_cnt - kv0, 32'd0);
    chk("bounce_onehot", {16'd0, onehot}, 32'd0);
    keys = 16'h0001;
    wait_kv("k0", lat);
    chk("k0_onehot", {16'd0, onehot}, 32'h0000_0001);
    chk("k0_code",   {28'd0, key_code}, 32'd0);
    keys = 16'h0000;
    repeat (80) @(negedge clk);

    // Chord 15+8, then release 8
    kv0 = kv_cnt;
    keys = 16'h8100;
    repeat (80) @(negedge clk);
    chk("chord_multi",  {31'd0, multi_key}, 32'd1);
    chk("chord_onehot", {16'd0, onehot}, 32'd0);
    chk("chord_no_strobe", kv_cnt - kv0, 32'd0);
    keys = 16'h8000;
    wait_kv("k15", lat);
    chk("k15_onehot", {16'd0, onehot}, 32'h0000_8000);
    chk("k15_multi",  {31'd0, multi_key}, 32'd0);
    chk("k15_code",   {28'd0, key_code}, 32'd15);
    keys = 16'h0000;
    repeat (80) @(negedge clk);

    // Repeated presses of the same key
    kv0 = kv_cnt;
    keys = 16'h0040; repeat (80) @(negedge clk);
    keys = 16'h0000; repeat (80) @(negedge clk);
    keys = 16'h0040; repeat (80) @(negedge clk);
    chk("repeat_two_pulses", kv_cnt - kv0, 32'd2);
    chk("repeat_code", {28'd0, key_code}, 32'd6);

    // Reset while key 6 is debounced and held
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_onehot", {16'd0, onehot}, 32'd0);
    chk("mid_rst_col",    {28'd0, col_out}, 32'h0000_000E);
    chk("mid_rst_code",   {28'd0, key_code}, 32'd0);
    rst = 1'b0;
    kv0 = kv_cnt;
    wait_kv("rerst", lat);
    chk("rerst_onehot", {16'd0, onehot}, 32'h0000_0040);
    chk("rerst_code",   {28'd0, key_code}, 32'd6);
    repeat (40) @(negedge clk);
    chk("rerst_one_pulse", kv_cnt - kv0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
